// File: rtl/gcd_euclid_ctrl.sv
// rtl/gcd_euclid_ctrl.sv - Sequential Euclidean GCD controller driving an external modulo unit
`timescale 1ns/1ps

module gcd_euclid_ctrl #(
    parameter int SIZE   = 16,
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [SIZE-1:0]   gcd,
    output logic [ITER_W-1:0] iterations,
    output logic              mod_start,
    output logic [SIZE-1:0]   mod_divident,
    output logic [SIZE-1:0]   mod_divisor,
    input  logic              mod_done,
    input  logic [SIZE-1:0]   mod_remainder
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    localparam logic [ITER_W-1:0] ITER_MAX = '1;

    logic [2:0]        state_q, state_d;
    logic [SIZE-1:0]   x_q, x_d;
    logic [SIZE-1:0]   y_q, y_d;
    logic [ITER_W-1:0] iter_q, iter_d;

    // Next-state and datapath update: x/y only move on WAIT exit so the
    // modulo unit sees stable operands for the whole request.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        iter_d  = iter_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = a;
                    y_d     = b;
                    iter_d  = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (y_q == '0) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mod_done) begin
                    x_d     = y_q;
                    y_d     = mod_remainder;
                    iter_d  = (iter_q == ITER_MAX) ? iter_q : iter_q + 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and operand registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            iter_q  <= iter_d;
        end
    end

    // Status and strobes decoded straight from the state register.
    always_comb begin
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_FINISH);
        mod_start    = (state_q == ST_ISSUE);
        gcd          = x_q;
        iterations   = iter_q;
        mod_divident = x_q;
        mod_divisor  = y_q;
    end

endmodule
